// File: rtl/dp_mem_responder.sv
// Arbitrates the datapath inst/data request ports onto one physical memory port
// and returns a single-cycle response pulse with read data to the requester.
module dp_mem_responder #(
    parameter int CNT_W    = 32,
    parameter bit DATA_PRI = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_read,
    input  logic [31:0]      inst_addr,
    output logic [31:0]      inst_rdata,
    output logic             inst_resp,
    input  logic             data_read,
    input  logic             data_write,
    input  logic [3:0]       data_mbe,
    input  logic [31:0]      data_addr,
    input  logic [31:0]      data_wdata,
    output logic [31:0]      data_rdata,
    output logic             data_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic [31:0]      pmem_addr,
    output logic [31:0]      pmem_wdata,
    output logic [3:0]       pmem_mbe,
    input  logic [31:0]      pmem_rdata,
    input  logic             pmem_resp,
    output logic [CNT_W-1:0] inst_cnt,
    output logic [CNT_W-1:0] data_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        I_BUSY,
        D_BUSY,
        RESP
    } state_e;

    state_e state_q, state_d;

    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       mbe_q, mbe_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             gnt_data_q, gnt_data_d;
    logic             last_data_q, last_data_d;
    logic             seen_conf_q, seen_conf_d;
    logic             keep_q, keep_d;
    logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;
    logic [CNT_W-1:0] data_cnt_q, data_cnt_d;

    logic inst_req;
    logic data_req;
    logic pick_data;
    logic unused_addr_bits;

    assign inst_req = inst_read;
    assign data_req = data_read | data_write;
    assign unused_addr_bits = ^data_addr[1:0];

    // Round-robin on conflict; the very first conflict falls back to DATA_PRI.
    always_comb begin
        pick_data = 1'b0;
        if (data_req && !inst_req) begin
            pick_data = 1'b1;
        end else if (data_req && inst_req) begin
            pick_data = seen_conf_q ? !last_data_q : DATA_PRI;
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mbe_d       = mbe_q;
        rdata_d     = rdata_q;
        gnt_data_d  = gnt_data_q;
        last_data_d = last_data_q;
        seen_conf_d = seen_conf_q;
        keep_d      = keep_q;
        inst_cnt_d  = inst_cnt_q;
        data_cnt_d  = data_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (inst_req || data_req) begin
                    seen_conf_d = seen_conf_q | (inst_req & data_req);
                    gnt_data_d  = pick_data;
                    if (pick_data) begin
                        state_d = D_BUSY;
                        rd_d    = !data_write;
                        wr_d    = data_write;
                        addr_d  = {data_addr[31:2], 2'b00};
                        wdata_d = data_wdata;
                        mbe_d   = data_write ? data_mbe : 4'hF;
                    end else begin
                        state_d = I_BUSY;
                        rd_d    = 1'b1;
                        wr_d    = 1'b0;
                        addr_d  = inst_addr;
                        wdata_d = '0;
                        mbe_d   = 4'hF;
                    end
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) begin
                    state_d     = RESP;
                    rd_d        = 1'b0;
                    wr_d        = 1'b0;
                    rdata_d     = wr_q ? '0 : pmem_rdata;
                    last_data_d = gnt_data_q;
                    // A dropped request means the op was flushed upstream.
                    keep_d      = gnt_data_q ? data_req : inst_req;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (keep_q && gnt_data_q && data_cnt_q != '1) begin
                    data_cnt_d = data_cnt_q + CNT_W'(1);
                end
                if (keep_q && !gnt_data_q && inst_cnt_q != '1) begin
                    inst_cnt_d = inst_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mbe_q       <= '0;
            rdata_q     <= '0;
            gnt_data_q  <= 1'b0;
            last_data_q <= 1'b0;
            seen_conf_q <= 1'b0;
            keep_q      <= 1'b0;
            inst_cnt_q  <= '0;
            data_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mbe_q       <= mbe_d;
            rdata_q     <= rdata_d;
            gnt_data_q  <= gnt_data_d;
            last_data_q <= last_data_d;
            seen_conf_q <= seen_conf_d;
            keep_q      <= keep_d;
            inst_cnt_q  <= inst_cnt_d;
            data_cnt_q  <= data_cnt_d;
        end
    end

    assign pmem_read  = rd_q;
    assign pmem_write = wr_q;
    assign pmem_addr  = addr_q;
    assign pmem_wdata = wdata_q;
    assign pmem_mbe   = mbe_q;

    assign inst_resp  = (state_q == RESP) && keep_q && !gnt_data_q;
    assign data_resp  = (state_q == RESP) && keep_q && gnt_data_q;
    assign inst_rdata = inst_resp ? rdata_q : '0;
    assign data_rdata = data_resp ? rdata_q : '0;

    assign inst_cnt = inst_cnt_q;
    assign data_cnt = data_cnt_q;

endmodule
